// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FSM state encoding, reset PC, exception vector and bubble instruction.
package ifu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } ifu_state_e;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_pc_sel.sv
// Next fetch-PC select: redirect/exception > sequential +4 > hold.
// Ports: fetch_pc, redirect, redirect_pc, exc, advance in; next_pc out.
module ifu_pc_sel
    import ifu_pkg::*;
(
    input  logic [31:0] fetch_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc,
    input  logic        advance,
    output logic [31:0] next_pc
);

    // Reset has the highest priority but is applied
    // asynchronously by the fetch_pc register itself.
    always_comb begin
        next_pc = fetch_pc;
        if (redirect) begin
            next_pc = exc ? EXC_VECTOR : redirect_pc;
        end else if (advance) begin
            next_pc = fetch_pc + 32'd4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: fetch PC, imem request, output slot {Instr_IF, pc_IF, if_valid}.
// Optional alignment check on redirect enabled by macro IFU_ALIGN_CHECK_EN.
module instr_fetch_unit
    import ifu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] Instr_IF,
    output logic [31:0] pc_IF,
    output logic        if_valid,
    output logic        exc_adel,
    output logic [31:0] badvaddr
);

    ifu_state_e  state_q;
    ifu_state_e  state_d;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic        consume;
    logic        slot_free;
    logic        fire;
    logic        exc;

    assign consume   = if_valid & ~stall;
    assign slot_free = ~if_valid | consume;
    // imem_req already excludes redirect, but ready is
    // masked explicitly so a stray word is never captured.
    assign fire      = imem_req & imem_ready & ~redirect;
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (halt) state_d = ST_HALT;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
        if (redirect) begin
            state_d = ST_FETCH;
        end
    end

    always_comb begin
        imem_req = (state_q == ST_FETCH) & slot_free & ~redirect;
    end

`ifdef IFU_ALIGN_CHECK_EN
    logic        exc_adel_q;
    logic [31:0] badvaddr_q;

    assign exc = redirect & misaligned(redirect_pc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_adel_q <= 1'b0;
            badvaddr_q <= 32'h0;
        end else begin
            exc_adel_q <= exc;
            if (exc) begin
                badvaddr_q <= redirect_pc;
            end
        end
    end

    assign exc_adel = exc_adel_q;
    assign badvaddr = badvaddr_q;
`else
    assign exc      = 1'b0;
    assign exc_adel = 1'b0;
    assign badvaddr = 32'h0;
`endif

    ifu_pc_sel u_pc_sel (
        .fetch_pc    (fetch_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc         (exc),
        .advance     (fire),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
        end else begin
            fetch_pc <= next_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instr_IF <= NOP_INSTR;
            pc_IF    <= RESET_PC;
            if_valid <= 1'b0;
        end else if (redirect) begin
            Instr_IF <= NOP_INSTR;
            if_valid <= 1'b0;
        end else if (fire) begin
            Instr_IF <= imem_rdata;
            pc_IF    <= fetch_pc;
            if_valid <= 1'b1;
        end else if (consume) begin
            Instr_IF <= NOP_INSTR;
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a wait-state memory model.
// Memory returns its address as data; expected values are hand-computed.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] Instr_IF;
    logic [31:0] pc_IF;
    logic        if_valid;
    logic        exc_adel;
    logic [31:0] badvaddr;

    int          errors;
    int          checks;
    int          mem_wait;
    int          cnt;
    logic        frc;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .Instr_IF    (Instr_IF),
        .pc_IF       (pc_IF),
        .if_valid    (if_valid),
        .exc_adel    (exc_adel),
        .badvaddr    (badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ready = (imem_req && cnt == mem_wait) || frc;
    assign imem_rdata = imem_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (!imem_req || imem_ready) cnt <= 0;
        else cnt <= cnt + 1;
    end

    typedef struct {
        logic        stall;
        logic        redirect;
        logic        halt;
        logic        frc;
        logic [31:0] rpc;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic s, logic r, logic h, logic f,
                                logic [31:0] rp, logic er, logic ev,
                                logic [31:0] ep);
        vec_t v;
        v.stall = s; v.redirect = r; v.halt = h; v.frc = f;
        v.rpc = rp; v.exp_req = er; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(string name);
        int n;
        n = 0;
        while (!if_valid && n < 20) begin
            tick();
            n++;
        end
        if (!if_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: if_valid got 0 expected 1 (timeout)", name);
        end
    endtask

    task automatic do_redirect(logic [31:0] addr);
        redirect    = 1'b1;
        redirect_pc = addr;
        tick();
        redirect    = 1'b0;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_req"},   {31'b0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
        chk({tag, "_pc"},    pc_IF,     32'h3000);
        chk({tag, "_instr"}, Instr_IF,  32'h0);
        chk({tag, "_addr"},  imem_addr, 32'h3000);
        chk({tag, "_exc"},   {31'b0, exc_adel}, 32'd0);
        chk({tag, "_bad"},   badvaddr,  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0;
        mem_wait = 0; frc = 1'b0;
        stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        redirect_pc = 32'h0;
        rst_n = 1'b0;

        // Table: inputs applied for one cycle, req checked
        // combinationally, slot checked after the edge.
        tbl[0]  = mk(0, 0, 0, 0, 32'h0,    0, 0, 32'h3000);
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,    1, 1, 32'h3000);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,    1, 1, 32'h3004);
        tbl[3]  = mk(1, 0, 0, 0, 32'h0,    0, 1, 32'h3004);
        tbl[4]  = mk(1, 0, 0, 0, 32'h0,    0, 1, 32'h3004);
        tbl[5]  = mk(1, 0, 0, 0, 32'h0,    0, 1, 32'h3004);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,    1, 1, 32'h3008);
        tbl[7]  = mk(0, 1, 0, 1, 32'h3100, 0, 0, 32'h0);
        tbl[8]  = mk(0, 0, 0, 0, 32'h0,    1, 1, 32'h3100);
        tbl[9]  = mk(0, 0, 0, 0, 32'h0,    1, 1, 32'h3104);
        tbl[10] = mk(0, 0, 1, 0, 32'h0,    1, 1, 32'h3108);
        tbl[11] = mk(0, 0, 0, 0, 32'h0,    0, 0, 32'h0);

        tick();
        chk_reset_vals("rst");
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            stall       = tbl[i].stall;
            redirect    = tbl[i].redirect;
            halt        = tbl[i].halt;
            frc         = tbl[i].frc;
            redirect_pc = tbl[i].rpc;
            #1;
            chk($sformatf("v%0d_req", i), {31'b0, imem_req},
                {31'b0, tbl[i].exp_req});
            tick();
            chk($sformatf("v%0d_valid", i), {31'b0, if_valid},
                {31'b0, tbl[i].exp_valid});
            chk($sformatf("v%0d_instr", i), Instr_IF,
                tbl[i].exp_valid ? tbl[i].exp_pc : 32'h0);
            if (tbl[i].exp_valid)
                chk($sformatf("v%0d_pc", i), pc_IF, tbl[i].exp_pc);
        end
        stall = 1'b0; redirect = 1'b0; halt = 1'b0; frc = 1'b0;

        // Halted: no requests for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("halt%0d_req", i), {31'b0, imem_req}, 32'd0);
            tick();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h3200;
        #1;
        chk("halt_redir_req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        chk("halt_redir_valid", {31'b0, if_valid}, 32'd0);
        #1;
        chk("resume_req", {31'b0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h3200);
        tick();
        chk("resume_pc", pc_IF, 32'h3200);
        chk("resume_instr", Instr_IF, 32'h3200);

        // PC wraps modulo 2^32.
        do_redirect(32'hFFFF_FFFC);
        wait_valid("wrap_a");
        chk("wrap_pc_a", pc_IF, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc_b", pc_IF, 32'h0000_0000);
        chk("wrap_valid_b", {31'b0, if_valid}, 32'd1);

        // Misaligned redirect.
        do_redirect(32'h3102);
`ifdef IFU_ALIGN_CHECK_EN
        chk("adel_pulse", {31'b0, exc_adel}, 32'd1);
        chk("adel_bad", badvaddr, 32'h3102);
        tick();
        chk("adel_clear", {31'b0, exc_adel}, 32'd0);
        chk("adel_bad_hold", badvaddr, 32'h3102);
        wait_valid("adel");
        chk("adel_pc", pc_IF, 32'h4180);
`else
        chk("noadel_pulse", {31'b0, exc_adel}, 32'd0);
        chk("noadel_bad", badvaddr, 32'h0);
        tick();
        wait_valid("noadel");
        chk("noadel_pc", pc_IF, 32'h3102);
`endif

        // Reset mid-request with a 2-wait-state memory.
        mem_wait = 2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_valid("ws_a");
        chk("ws_pc_a", pc_IF, 32'h3000);
        tick();
        wait_valid("ws_b");
        chk("ws_pc_b", pc_IF, 32'h3004);
        tick();
        chk("ws_pre_req", {31'b0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        rst_n = 1'b1;
        wait_valid("ws_c");
        chk("ws_pc_c", pc_IF, 32'h3000);
        chk("ws_instr_c", Instr_IF, 32'h3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
